pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: forwarding selects, load-use stall,
// redirect flush, and a data-memory wait with timeout and stall statistics.
module pipe_hazard_fwd (
  input  logic [4:0] rs,
  input  logic [4:0] rdm,
  input  logic [4:0] rdw,
  input  logic       regwritem,
  input  logic       regwritew,
  input  logic       en,
  output logic [1:0] sel
);
  // The M-stage value is younger, so it wins over W; x0 is hardwired zero.
  always_comb begin
    sel = 2'b00;
    if (en) begin
      if (regwritem && rdm != 5'd0 && rdm == rs)      sel = 2'b10;
      else if (regwritew && rdw != 5'd0 && rdw == rs) sel = 2'b01;
    end
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int START_CYC = 2,
  parameter int WAIT_MAX  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1d,
  input  logic [4:0]  rs2d,
  input  logic [4:0]  rs1e,
  input  logic [4:0]  rs2e,
  input  logic [4:0]  rde,
  input  logic [4:0]  rdm,
  input  logic [4:0]  rdw,
  input  logic        regwritem,
  input  logic        regwritew,
  input  logic [1:0]  resultsrce,
  input  logic [1:0]  pcsrce,
  input  logic        memreqm,
  input  logic        memreadym,
  output logic        stallf,
  output logic        stalld,
  output logic        flushd,
  output logic        flushe,
  output logic        stallx,
  output logic [1:0]  fwae,
  output logic [1:0]  fwbe,
  output logic        err,
  output logic [15:0] stall_cnt
);
  localparam int SW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam int WW = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {START, RUN, MWAIT} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] start_cnt;
  logic [WW-1:0] wait_cnt;
  logic          lwstall, redirect, memwait;
  logic          start_done, wait_to, err_set;

  logic [1:0][4:0] rs_e;
  logic [1:0][1:0] fwd;

  assign rs_e = {rs2e, rs1e};

  // Operand 0 feeds ALU input A, operand 1 feeds input B; gated off in reset.
  generate
    for (genvar g = 0; g < 2; g++) begin : g_fwd
      pipe_hazard_fwd u_fwd (
        .rs        (rs_e[g]),
        .rdm       (rdm),
        .rdw       (rdw),
        .regwritem (regwritem),
        .regwritew (regwritew),
        .en        (rst),
        .sel       (fwd[g])
      );
    end
  endgenerate

  assign fwae = fwd[0];
  assign fwbe = fwd[1];

  always_comb begin
    lwstall    = (resultsrce == 2'b01) && (rde != 5'd0) && (rde == rs1d || rde == rs2d);
    redirect   = (pcsrce != 2'b00);
    memwait    = memreqm && !memreadym;
    start_done = (start_cnt == SW'(START_CYC - 1));
    wait_to    = (wait_cnt == WW'(WAIT_MAX - 1));
    state_nxt  = state;
    stallf     = 1'b0;
    stalld     = 1'b0;
    stallx     = 1'b0;
    flushd     = 1'b0;
    flushe     = 1'b0;
    err_set    = 1'b0;
    case (state)
      START: begin
        flushd = 1'b1;
        flushe = 1'b1;
        if (start_done) state_nxt = RUN;
      end
      RUN: begin
        // A memory wait freezes E, so any redirect there is picked up later.
        if (memwait) begin
          stallf    = 1'b1;
          stalld    = 1'b1;
          stallx    = 1'b1;
          state_nxt = MWAIT;
        end else begin
          stallf = lwstall && !redirect;
          stalld = lwstall && !redirect;
          flushd = redirect;
          flushe = lwstall || redirect;
        end
      end
      MWAIT: begin
        if (memreadym) begin
          stallf    = lwstall && !redirect;
          stalld    = lwstall && !redirect;
          flushd    = redirect;
          flushe    = lwstall || redirect;
          state_nxt = RUN;
        end else begin
          stallf = 1'b1;
          stalld = 1'b1;
          stallx = 1'b1;
          if (wait_to) begin
            err_set   = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= START;
      start_cnt <= '0;
      wait_cnt  <= '0;
      err       <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      start_cnt <= (state == START && !start_done) ? start_cnt + SW'(1) : '0;
      wait_cnt  <= (state == MWAIT && !memreadym && !wait_to) ? wait_cnt + WW'(1) : '0;
      if (err_set) err <= 1'b1;
      if (stallf && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule
